// File: rtl/seq_lshifter32_pkg.sv
// Shared constants and state encoding for the sequential left shifter of the ALU datapath.
// The state constants are plain localparams so legacy blocks can reuse the same encoding.
package seq_lshifter32_pkg;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'b00;
  localparam state_t ST_SHIFT = 2'b01;
  localparam state_t ST_DONE  = 2'b10;

endpackage

// File: rtl/seq_lshifter32_stage_mux.sv
// One iteration of the left barrel shifter: picks the fixed power-of-two shift for the
// current stage and applies it only when that stage's amount bit is set.
module lshift_stage_mux #(
  parameter int W = seq_lshifter32_pkg::WIDTH
) (
  input  logic [W-1:0] acc_i,
  input  logic [2:0]   stage_i,
  input  logic         amt_bit_i,
  output logic [W-1:0] acc_o
);

  logic [W-1:0] shifted;

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    shifted = acc_i;
    case (stage_i)
      3'd0:    shifted = {acc_i[W-2:0],  1'b0};
      3'd1:    shifted = {acc_i[W-3:0],  2'b0};
      3'd2:    shifted = {acc_i[W-5:0],  4'b0};
      3'd3:    shifted = {acc_i[W-9:0],  8'b0};
      3'd4:    shifted = {acc_i[W-17:0], 16'b0};
      default: shifted = acc_i;
    endcase
  end

  assign acc_o = amt_bit_i ? shifted : acc_i;

endmodule

// File: rtl/seq_lshifter32.sv
// Multi-cycle logical left shifter: one barrel stage per clock, Start/Busy/Done handshake,
// result gated onto Out by Enable like the other ALU operation units.
module seq_lshifter32
  import seq_lshifter32_pkg::state_t;
  import seq_lshifter32_pkg::ST_IDLE;
  import seq_lshifter32_pkg::ST_SHIFT;
  import seq_lshifter32_pkg::ST_DONE;
#(
  parameter int WIDTH = seq_lshifter32_pkg::WIDTH,
  parameter int SHW   = seq_lshifter32_pkg::SHW
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic             Enable,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Out
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   amt_q, amt_d;
  logic [2:0]       stage_q, stage_d;

  logic [WIDTH-1:0] acc_shifted;
  logic [7:0]       amt_ext;
  logic             amt_bit;

  // Upper amount bits are deliberately ignored: shifts are taken modulo WIDTH.
  logic unused_in2_hi;
  assign unused_in2_hi = ^In2[WIDTH-1:SHW];

  assign amt_ext = 8'(amt_q);
  assign amt_bit = amt_ext[stage_q];

  lshift_stage_mux #(.W(WIDTH)) u_stage_mux (
    .acc_i     (acc_q),
    .stage_i   (stage_q),
    .amt_bit_i (amt_bit),
    .acc_o     (acc_shifted)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    stage_d = stage_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_SHIFT;
          acc_d   = In1;
          amt_d   = In2[SHW-1:0];
          stage_d = 3'd0;
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shifted;
        if (stage_q == 3'(SHW - 1)) begin
          state_d = ST_DONE;
        end else begin
          stage_d = stage_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      amt_q   <= '0;
      stage_q <= 3'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
      stage_q <= stage_d;
    end
  end

  assign Busy = (state_q == ST_SHIFT);
  assign Done = (state_q == ST_DONE);
  assign Out  = acc_q & {WIDTH{Enable}};

endmodule

// File: tb/tb_seq_lshifter32.sv
// Self-checking bench for seq_lshifter32: directed handshake/reset/enable cases plus random
// operands compared against an arithmetic model of a modulo-32 logical left shift.
module tb_seq_lshifter32;

  logic        Clk;
  logic        Rst;
  logic        Start;
  logic [31:0] In1;
  logic [31:0] In2;
  logic        Enable;
  logic        Busy;
  logic        Done;
  logic [31:0] Out;

  int total = 0;
  int bad   = 0;

  seq_lshifter32 dut (
    .Clk    (Clk),
    .Rst    (Rst),
    .Start  (Start),
    .In1    (In1),
    .In2    (In2),
    .Enable (Enable),
    .Busy   (Busy),
    .Done   (Done),
    .Out    (Out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Left shift as multiplication by 2^(amount mod 32), keeping the low 32 bits.
  function automatic logic [31:0] ref_shl(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * (64'd1 << (b % 32));
    return p[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one op from an IDLE cycle and checks Busy for 5 cycles, then Done and Out.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    @(negedge Clk);
    Start = 1'b1;
    In1   = a;
    In2   = b;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      if (i == 0) begin
        Start = 1'b0;
        In1   = $urandom;
        In2   = $urandom;
      end
      check({tag, " busy"}, 32'(Busy), 32'd1);
      check({tag, " no_done"}, 32'(Done), 32'd0);
    end
    @(negedge Clk);
    check({tag, " done"}, 32'(Done), 32'd1);
    check({tag, " busy_low"}, 32'(Busy), 32'd0);
    check({tag, " out"}, Out, Enable ? exp : 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    Rst    = 1'b1;
    Start  = 1'b0;
    In1    = 32'd0;
    In2    = 32'd0;
    Enable = 1'b1;

    // Reset state
    repeat (2) @(negedge Clk);
    check("rst busy", 32'(Busy), 32'd0);
    check("rst done", 32'(Done), 32'd0);
    check("rst out", Out, 32'd0);
    Rst = 1'b0;

    // Directed amounts, including 0, 31 and ignored upper amount bits
    run_op(32'h0000_0001, 32'd4,          32'h0000_0010, "shl4");
    run_op(32'h8000_0001, 32'd31,         32'h8000_0000, "shl31");
    run_op(32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF, "shl0");
    run_op(32'h1234_5678, 32'hFFFF_FFE8,  32'h3456_7800, "shl_hi_ignored");
    run_op(32'hFFFF_FFFF, 32'd16,         32'hFFFF_0000, "shl16");

    // Result holds in IDLE
    repeat (3) @(negedge Clk);
    check("idle hold out", Out, 32'hFFFF_0000);
    check("idle hold done", 32'(Done), 32'd0);

    // Start re-pulsed during Busy and DONE with other operands is ignored
    @(negedge Clk);
    Start = 1'b1;
    In1   = 32'h0000_0003;
    In2   = 32'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      In1 = 32'hAAAA_5555;
      In2 = 32'd7;
      check("repulse busy", 32'(Busy), 32'd1);
      check("repulse no_done", 32'(Done), 32'd0);
    end
    @(negedge Clk);
    check("repulse done", 32'(Done), 32'd1);
    check("repulse out", Out, 32'h0000_000C);
    @(negedge Clk);
    Start = 1'b0;
    check("repulse idle busy", 32'(Busy), 32'd0);
    check("repulse idle done", 32'(Done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("repulse no_second_done", 32'(Done), 32'd0);
      check("repulse no_second_busy", 32'(Busy), 32'd0);
    end
    check("repulse out kept", Out, 32'h0000_000C);
    run_op(32'h0000_0005, 32'd3, 32'h0000_0028, "after_repulse");

    // Reset during the third SHIFT cycle discards the operation
    @(negedge Clk);
    Start = 1'b1;
    In1   = 32'h0000_00FF;
    In2   = 32'd1;
    @(negedge Clk);
    Start = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    check("pre_rst busy", 32'(Busy), 32'd1);
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    check("midrst busy", 32'(Busy), 32'd0);
    check("midrst done", 32'(Done), 32'd0);
    check("midrst out", Out, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      check("midrst no_done", 32'(Done), 32'd0);
      check("midrst no_busy", 32'(Busy), 32'd0);
    end

    // Enable gating is combinational and leaves the state machine alone
    run_op(32'h0000_000F, 32'd8, 32'h0000_0F00, "en_base");
    Enable = 1'b0;
    #1;
    check("en_low out", Out, 32'd0);
    Enable = 1'b1;
    #1;
    check("en_high out", Out, 32'h0000_0F00);
    Enable = 1'b0;
    run_op(32'h0000_00F0, 32'd4, 32'h0000_0F00, "en_low_during_shift");
    Enable = 1'b1;
    #1;
    check("en_restore out", Out, 32'h0000_0F00);

    // Random operands against the arithmetic model
    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_op(ra, rb, ref_shl(ra, rb), "rand");
    end

    repeat (2) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
